washer_plant_model: RTL and testbench
=====================================

Name: washer_plant_model

Overview:
- Behavioural responder for the washing-machine controller interface: consumes the controller's actuator outputs and generates its sensor/timer inputs.
- Sits opposite the controller in system-level sims and on the FPGA demo build.
- Models water level, detergent dispensing, wash-cycle timer and spin timer with parameterised durations.
- Flags illegal actuator combinations via a sticky fault output.

Parameters:
- FILL_CYCLES, 8, clocks of fill valve needed to go from empty to full (level max); must be ≥2.
- DRAIN_CYCLES, 4, clocks of drain valve per level unit removed is 1; level drops by FILL_CYCLES/DRAIN_CYCLES per clock (integer, ≥1); default gives 2 per clock.
- DET_CYCLES, 2, clocks of soap_wash while filled before detergent_added asserts.
- WASH_CYCLES, 12, clocks of agitation before cycle_timeout asserts.
- SPIN_CYCLES, 10, clocks of spin before spin_timeout asserts.
- LEAK_PERIOD, 16, clocks between leak decrements (used only with WASHER_PLANT_LEAK_EN).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- door_lock  input  1  controller door lock
- motor_on  input  1  controller motor drive
- fill_value_on  input  1  controller fill valve
- drain_value_on  input  1  controller drain valve
- soap_wash  input  1  controller in soap-wash phase
- water_wash  input  1  controller in rinse phase
- done  input  1  controller cycle complete
- filled  output  1  level == FILL_CYCLES
- drained  output  1  level == 0
- detergent_added  output  1  detergent dispensed (sticky)
- cycle_timeout  output  1  wash timer expired (sticky while motor_on)
- spin_timeout  output  1  spin timer expired (sticky while motor_on)
- level  output  $clog2(FILL_CYCLES+1)  current water level
- fault  output  1  sticky illegal-combination flag

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-high (ports clk, reset). All state registered; outputs decoded from registers only.
- Reset values: level=0, drained=1, filled=0, detergent_added=0, cycle_timeout=0, spin_timeout=0, fault=0, all counters 0. Reset asserted mid-operation clears everything immediately, regardless of clk.
- Level:
  - fill_value_on & !drain_value_on → +1 per clock, saturating at FILL_CYCLES.
  - drain_value_on & !fill_value_on → −(FILL_CYCLES/DRAIN_CYCLES) per clock, saturating at 0 (no underflow wrap).
  - Both or neither → hold.
- Detergent:
  - det_cnt increments while soap_wash & filled & !detergent_added.
  - On reaching DET_CYCLES, detergent_added←1 and det_cnt←0.
  - detergent_added stays 1 until done=1 or reset.
  - det_cnt clears whenever its condition drops.
- Wash timer:
  - wash_cnt increments while motor_on & door_lock & filled & (soap_wash|water_wash) & !drain_value_on; saturates at WASH_CYCLES.
  - cycle_timeout = (wash_cnt==WASH_CYCLES).
  - wash_cnt clears when motor_on=0 or done=1.
  - A soap_wash→water_wash change without motor_on dropping does not restart the timer.
- Spin timer:
  - spin_cnt increments while motor_on & door_lock & drain_value_on & drained; saturates at SPIN_CYCLES.
  - spin_timeout = (spin_cnt==SPIN_CYCLES).
  - spin_cnt clears on motor_on=0 or done=1.
- done=1: clears detergent_added, wash_cnt and spin_cnt the same edge; level untouched. done has priority over simultaneous count conditions.
- Fault: set on any edge where (fill_value_on & drain_value_on) or (motor_on & !door_lock) or (fill_value_on & !door_lock). Sticky until reset. Does not stall modelling.
- Latency: input change affects counters on the next rising edge; outputs reflect the new count the same cycle the register updates.

Optional Feature:
- Macro: WASHER_PLANT_LEAK_EN.
- Defined:
  - Free-running leak_cnt wraps every LEAK_PERIOD clocks.
  - On wrap, if level>0 and fill_value_on=0, level decrements by 1, in addition to any drain (combined saturates at 0).
  - A leak while filled drops filled; the wash timer then pauses (holds, not cleared).
- Undefined: no leak counter synthesised; level changes only via valves.

Test Plan:
- Reset then fill_value_on=1 for 8 clocks → level 0..8, filled=1 after 8th edge, drained=0 after 1st edge; 9th clock level stays 8.
- Filled, soap_wash=1 2 clocks → detergent_added=1 on 2nd edge; done pulse → detergent_added=0 next edge.
- Filled, motor_on=door_lock=soap_wash=1 for 12 clocks → cycle_timeout=1 on 12th edge, held; motor_on=0 → cycle_timeout=0 next edge.
- From level 8, drain_value_on=1 → level 6,4,2,0, drained=1 on 4th edge; then motor_on=door_lock=1 for 10 more clocks → spin_timeout=1 on 10th.
- fill_value_on=drain_value_on=1 one clock → fault=1, level held; fault stays 1 until reset; reset asserted between edges clears fault and level asynchronously.
- With WASHER_PLANT_LEAK_EN, level=8, valves off 32 clocks → level=6, filled=0 after first leak (edge 16).

Source files
------------

// File: rtl/washer_plant_model.sv
// Behavioural plant for the washer controller: water level, detergent, wash/spin timers, sticky fault.
// Ports: clk, reset (async high), actuator inputs in; level/timer/fault sensors out. Optional leak: WASHER_PLANT_LEAK_EN.
module washer_plant_model #(
  parameter int FILL_CYCLES  = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int DET_CYCLES   = 2,
  parameter int WASH_CYCLES  = 12,
  parameter int SPIN_CYCLES  = 10,
  parameter int LEAK_PERIOD  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic door_lock,
  input  logic motor_on,
  input  logic fill_value_on,
  input  logic drain_value_on,
  input  logic soap_wash,
  input  logic water_wash,
  input  logic done,
  output logic filled,
  output logic drained,
  output logic detergent_added,
  output logic cycle_timeout,
  output logic spin_timeout,
  output logic [$clog2(FILL_CYCLES+1)-1:0] level,
  output logic fault
);

  localparam int LW   = $clog2(FILL_CYCLES+1);
  localparam int DW   = $clog2(DET_CYCLES+1);
  localparam int WW   = $clog2(WASH_CYCLES+1);
  localparam int SW   = $clog2(SPIN_CYCLES+1);
  localparam int STEP = FILL_CYCLES / DRAIN_CYCLES;

  logic [DW-1:0] det_cnt;
  logic [WW-1:0] wash_cnt;
  logic [SW-1:0] spin_cnt;
  logic [LW-1:0] level_d;
  logic          bad_combo;
  logic          det_cond;
  logic          wash_cond;
  logic          spin_cond;
  logic          leak;

  assign filled        = (level == LW'(FILL_CYCLES));
  assign drained       = (level == '0);
  assign cycle_timeout = (wash_cnt == WW'(WASH_CYCLES));
  assign spin_timeout  = (spin_cnt == SW'(SPIN_CYCLES));

  assign bad_combo = (fill_value_on & drain_value_on)
                   | (motor_on & ~door_lock)
                   | (fill_value_on & ~door_lock);
  assign det_cond  = soap_wash & filled & ~detergent_added;
  assign wash_cond = motor_on & door_lock & filled
                   & (soap_wash | water_wash) & ~drain_value_on;
  assign spin_cond = motor_on & door_lock & drain_value_on & drained;

`ifdef WASHER_PLANT_LEAK_EN
  localparam int KW = $clog2(LEAK_PERIOD);
  logic [KW-1:0] leak_cnt;
  assign leak = (leak_cnt == KW'(LEAK_PERIOD-1))
              & ~drained & ~fill_value_on;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) leak_cnt <= '0;
    else if (leak_cnt == KW'(LEAK_PERIOD-1)) leak_cnt <= '0;
    else leak_cnt <= leak_cnt + 1'b1;
  end
`else
  assign leak = 1'b0;
`endif

  // Signed arithmetic so drain plus leak saturates at zero instead of wrapping.
  always_comb begin
    int nxt;
    nxt = int'(level);
    if (fill_value_on && !drain_value_on) begin
      nxt = nxt + 1;
    end else if (drain_value_on && !fill_value_on) begin
      nxt = nxt - STEP;
    end
    if (leak) nxt = nxt - 1;
    if (nxt > FILL_CYCLES) nxt = FILL_CYCLES;
    if (nxt < 0) nxt = 0;
    level_d = LW'(nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level           <= '0;
      fault           <= 1'b0;
      detergent_added <= 1'b0;
      det_cnt         <= '0;
      wash_cnt        <= '0;
      spin_cnt        <= '0;
    end else begin
      level <= level_d;
      if (bad_combo) fault <= 1'b1;

      if (done) begin
        detergent_added <= 1'b0;
        det_cnt         <= '0;
      end else if (det_cond) begin
        if (det_cnt == DW'(DET_CYCLES-1)) begin
          detergent_added <= 1'b1;
          det_cnt         <= '0;
        end else begin
          det_cnt <= det_cnt + 1'b1;
        end
      end else begin
        det_cnt <= '0;
      end

      // Phase change soap->rinse keeps the count; only motor drop or done restarts it.
      if (!motor_on || done) wash_cnt <= '0;
      else if (wash_cond && !cycle_timeout) wash_cnt <= wash_cnt + 1'b1;

      if (!motor_on || done) spin_cnt <= '0;
      else if (spin_cond && !spin_timeout) spin_cnt <= spin_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_washer_plant_model.sv
// Self-checking bench for washer_plant_model: directed plan plus random actuators vs a reference model.
// Ports of the DUT are driven at negedge and sampled at negedge.
module tb_washer_plant_model;

  localparam int F  = 8;
  localparam int D  = 4;
  localparam int DC = 2;
  localparam int WC = 12;
  localparam int SC = 10;
  localparam int LP = 16;

  logic clk = 0;
  logic reset = 1;
  logic door_lock = 0, motor_on = 0, fill_value_on = 0, drain_value_on = 0;
  logic soap_wash = 0, water_wash = 0, done = 0;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
  logic [3:0] level;

  int total = 0;
  int bad = 0;

  washer_plant_model dut (
    .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .level(level), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: water volume, elapsed phase times, sticky flags.
  int  m_level, m_det_t, m_wash_t, m_spin_t, m_leak_t;
  bit  m_det, m_fault;

  always @(posedge clk or posedge reset) begin
    int  nl;
    bit  full, empty;
    if (reset) begin
      m_level <= 0; m_det_t <= 0; m_wash_t <= 0;
      m_spin_t <= 0; m_leak_t <= 0; m_det <= 0; m_fault <= 0;
    end else begin
      full  = (m_level == F);
      empty = (m_level == 0);
      nl = m_level;
      if (fill_value_on && !drain_value_on) nl = nl + 1;
      if (drain_value_on && !fill_value_on) nl = nl - F / D;
`ifdef WASHER_PLANT_LEAK_EN
      if ((m_leak_t % LP) == LP - 1 && m_level > 0 && !fill_value_on) nl = nl - 1;
`endif
      m_leak_t <= m_leak_t + 1;
      m_level <= (nl > F) ? F : (nl < 0 ? 0 : nl);
      if ((fill_value_on && drain_value_on) || (motor_on && !door_lock) ||
          (fill_value_on && !door_lock)) m_fault <= 1;
      if (done) begin
        m_det <= 0; m_det_t <= 0;
      end else if (soap_wash && full && !m_det) begin
        if (m_det_t + 1 >= DC) begin m_det <= 1; m_det_t <= 0; end
        else m_det_t <= m_det_t + 1;
      end else m_det_t <= 0;
      if (!motor_on || done) m_wash_t <= 0;
      else if (door_lock && full && (soap_wash || water_wash) && !drain_value_on)
        m_wash_t <= (m_wash_t + 1 > WC) ? WC : m_wash_t + 1;
      if (!motor_on || done) m_spin_t <= 0;
      else if (door_lock && drain_value_on && empty)
        m_spin_t <= (m_spin_t + 1 > SC) ? SC : m_spin_t + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_level", int'(level), m_level);
    chk("m_filled", int'(filled), int'(m_level == F));
    chk("m_drained", int'(drained), int'(m_level == 0));
    chk("m_det", int'(detergent_added), int'(m_det));
    chk("m_cto", int'(cycle_timeout), int'(m_wash_t == WC));
    chk("m_sto", int'(spin_timeout), int'(m_spin_t == SC));
    chk("m_fault", int'(fault), int'(m_fault));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    step(2);
    reset = 0;
    chk("rst_level", int'(level), 0);
    chk("rst_drained", int'(drained), 1);
    chk("rst_filled", int'(filled), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_det", int'(detergent_added), 0);

    door_lock = 1; fill_value_on = 1;
    for (int i = 1; i <= F; i++) begin
      step(1);
      chk("fill_level", int'(level), i);
      if (i == 1) chk("fill_drained0", int'(drained), 0);
      if (i < F) chk("fill_notfull", int'(filled), 0);
    end
    chk("fill_full", int'(filled), 1);
    step(1);
    chk("fill_sat", int'(level), F);
    fill_value_on = 0;

    soap_wash = 1;
    step(1); chk("det_1", int'(detergent_added), 0);
    step(1); chk("det_2", int'(detergent_added), 1);
    soap_wash = 0; done = 1;
    step(1); chk("det_done", int'(detergent_added), 0);
    done = 0;

    motor_on = 1; soap_wash = 1;
    for (int i = 1; i < WC; i++) begin
      step(1); chk("wash_run", int'(cycle_timeout), 0);
    end
    step(1); chk("wash_to", int'(cycle_timeout), 1);
    soap_wash = 0; water_wash = 1;
    step(1); chk("wash_hold", int'(cycle_timeout), 1);
    motor_on = 0; water_wash = 0;
    step(1); chk("wash_clr", int'(cycle_timeout), 0);

    drain_value_on = 1;
    for (int i = 1; i <= 4; i++) begin
      step(1); chk("drain_level", int'(level), F - 2 * i);
    end
    chk("drain_empty", int'(drained), 1);
    motor_on = 1;
    for (int i = 1; i < SC; i++) begin
      step(1); chk("spin_run", int'(spin_timeout), 0);
    end
    step(1); chk("spin_to", int'(spin_timeout), 1);
    step(1); chk("spin_under", int'(level), 0);
    motor_on = 0; drain_value_on = 0;
    step(1); chk("spin_clr", int'(spin_timeout), 0);

    fill_value_on = 1;
    step(3); chk("refill", int'(level), 3);
    drain_value_on = 1;
    step(1);
    chk("fault_set", int'(fault), 1);
    chk("fault_hold_lvl", int'(level), 3);
    fill_value_on = 0; drain_value_on = 0;
    step(2); chk("fault_sticky", int'(fault), 1);
    #2 reset = 1;
    #1;
    chk("arst_fault", int'(fault), 0);
    chk("arst_level", int'(level), 0);
    #1 reset = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      door_lock      = ($urandom_range(0, 9) != 0);
      motor_on       = ($urandom_range(0, 2) != 0);
      fill_value_on  = ($urandom_range(0, 2) == 0);
      drain_value_on = ($urandom_range(0, 2) == 0);
      soap_wash      = $urandom_range(0, 1);
      water_wash     = $urandom_range(0, 1);
      done           = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1;
        #1 reset = 0;
      end
    end
    step(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
